pq_accel_dispatch: RTL and testbench
====================================

Name: pq_accel_dispatch

Overview:
- Parametrised EX-stage dispatcher for post-quantum accelerator units. Successor to the fixed-function, 9-way one-hot enable/result mux.
- Routes one decoded accelerator instruction to one of NUM_UNITS units and runs a start/done handshake with multicycle units.
- Captures the result in a register and holds it until the pipeline accepts it.
- Adds a per-operation timeout and a sticky error flag.

Parameters:
- NUM_UNITS, 8, number of unit channels (1..16).
- DATA_WIDTH, 32, operand and result width.
- COMB_MASK, 8'b0000_0110, bit i=1: unit i is combinational (result valid in the same cycle, no handshake).
- PRESENT_MASK, 8'hFF, bit i=1: unit i is instantiated. Absent units are treated as illegal.
- TIMEOUT_CYCLES, 1023, maximum BUSY cycles before abort.
- TW, 10, timeout counter width (TIMEOUT_CYCLES < 2^TW).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- enable_i  in  1  valid accelerator instruction in EX.
- unit_idx_i  in  $clog2(NUM_UNITS)  target unit index.
- op_a_i / op_b_i / op_c_i  in  DATA_WIDTH each  operands.
- ex_ready_i  in  1  pipeline accepts the EX result this cycle.
- err_clr_i  in  1  clears error_o.
- result_o  out  DATA_WIDTH  result to the pipeline.
- ready_o  out  1  result_o valid / accelerator not stalling.
- multicycle_o  out  1  equals ~ready_o.
- error_o  out  1  sticky: timeout or illegal unit seen.
- unit_start_o  out  NUM_UNITS  one-cycle start pulse, one-hot.
- unit_op_a_o / unit_op_b_o / unit_op_c_o  out  DATA_WIDTH each  operands broadcast to all units.
- unit_done_i  in  NUM_UNITS  per-unit done pulse.
- unit_result_i  in  NUM_UNITS*DATA_WIDTH  unit i drives slice [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- States: IDLE, BUSY, HOLD.
- Reset (async, rst_n=0):
  - state=IDLE; idx_q, op regs, result_q, counter=0; error_o=0.
  - Outputs in reset: ready_o=1, multicycle_o=0, unit_start_o=0, result_o=0.
  - Reset mid-BUSY abandons the operation. No start is re-issued.
- IDLE, enable_i=0: ready_o=1, result_o=0, unit_op_*_o=op_*_i.
- IDLE, enable_i=1, unit illegal (idx>=NUM_UNITS or PRESENT_MASK[idx]=0):
  - ready_o=1, result_o=0.
  - error_o set on the next edge. No start issued.
- IDLE, enable_i=1, COMB_MASK[idx]=1:
  - ready_o=1, result_o=unit_result_i slice idx, same cycle (0 latency). No state change.
- IDLE, enable_i=1, multicycle unit:
  - unit_start_o[idx]=1 for this cycle only; ready_o=0.
  - Latch idx, op_a/b/c; counter=0; next state BUSY.
- BUSY:
  - ready_o=0, unit_start_o=0, unit_op_*_o=latched ops (stable).
  - Counter increments each cycle.
  - unit_done_i[idx_q]=1: result_q<=slice idx_q; next state HOLD.
  - Done from any other unit is ignored.
  - Else if counter==TIMEOUT_CYCLES-1: result_q<=0, error_o<=1, next state HOLD.
  - Done and timeout in the same cycle: done wins, no error.
  - enable_i changes during BUSY are ignored.
- HOLD:
  - ready_o=1, result_o=result_q, no start.
  - ex_ready_i=1: next state IDLE. Else stay (result held, no re-dispatch even though enable_i stays high).
- Latency (multicycle unit): done arriving k cycles after start gives ready_o=1 at cycle k+1 after the start cycle.
- error_o: set on timeout or illegal unit; cleared by err_clr_i. If set and clear coincide, set wins.
- result_o is 0 whenever ready_o=0.
- unit_start_o is never asserted outside IDLE. At most one bit is set.

Test Plan:
- Comb unit: idx=1, unit 1 result 0x0000_00AB, enable_i=1 -> same cycle ready_o=1, result_o=0xAB, unit_start_o=0, state stays IDLE.
- Multicycle unit: idx=0, op_a=0x1234, unit 0 done 5 cycles after start with 0xDEAD_BEEF -> unit_start_o=8'h01 for exactly 1 cycle; unit_op_a_o=0x1234 throughout BUSY; ready_o=0 for 6 cycles, then result_o=0xDEADBEEF.
- Hold/backpressure: after the previous case, hold ex_ready_i=0 for 3 cycles with enable_i=1 -> result_o stays 0xDEADBEEF, ready_o stays 1, no second start. ex_ready_i=1 -> IDLE next cycle.
- Spurious and simultaneous done:
  - idx=3 busy; unit_done_i[5] pulses -> ignored, stay BUSY.
  - TIMEOUT_CYCLES=4, done[3] on the counter==3 cycle -> HOLD with unit 3 result, error_o=0.
- Timeout/illegal: TIMEOUT_CYCLES=4, no done -> after 4 BUSY cycles result_o=0, ready_o=1, error_o=1. idx with PRESENT_MASK bit 0 -> ready_o=1, result 0, error_o=1. err_clr_i -> error_o=0.
- Async reset mid-BUSY: assert rst_n=0 between edges -> immediately ready_o=1, multicycle_o=0, error_o=0. After release, a new dispatch works normally.

Source files
------------

// File: rtl/pq_accel_dispatch.sv
// EX-stage dispatcher for post-quantum accelerator units.
// Routes one instruction to a unit. Combinational units answer in the same cycle.
// Multicycle units get a start/done handshake with a timeout.
// The captured result is held until the pipeline accepts it.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | no operation in flight; comb units answered directly
//   S_BUSY | waiting for done from unit idx_q, timeout counter running
//   S_HOLD | result_q presented to the pipeline until ex_ready_i
module pq_accel_dispatch #(
  parameter int                   NUM_UNITS      = 8,
  parameter int                   DATA_WIDTH     = 32,
  parameter logic [NUM_UNITS-1:0] COMB_MASK      = 8'b0000_0110,
  parameter logic [NUM_UNITS-1:0] PRESENT_MASK   = 8'hFF,
  parameter int                   TIMEOUT_CYCLES = 1023,
  parameter int                   TW             = 10,
  localparam int                  IW             = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable_i,
  input  logic [IW-1:0]                   unit_idx_i,
  input  logic [DATA_WIDTH-1:0]           op_a_i,
  input  logic [DATA_WIDTH-1:0]           op_b_i,
  input  logic [DATA_WIDTH-1:0]           op_c_i,
  input  logic                            ex_ready_i,
  input  logic                            err_clr_i,
  output logic [DATA_WIDTH-1:0]           result_o,
  output logic                            ready_o,
  output logic                            multicycle_o,
  output logic                            error_o,
  output logic [NUM_UNITS-1:0]            unit_start_o,
  output logic [DATA_WIDTH-1:0]           unit_op_a_o,
  output logic [DATA_WIDTH-1:0]           unit_op_b_o,
  output logic [DATA_WIDTH-1:0]           unit_op_c_o,
  input  logic [NUM_UNITS-1:0]            unit_done_i,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0] unit_result_i
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0] op_a_q, op_b_q, op_c_q, result_q;
  logic [TW-1:0]         cnt_q;
  logic                  error_q;

  logic [DATA_WIDTH-1:0] res_arr [NUM_UNITS];
  logic                  legal, is_comb, done_hit, timeout;
  logic                  launch, err_set;
  logic [DATA_WIDTH-1:0] sel_res;

  // Unpack the flat result bus into one word per unit.
  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      res_arr[i] = unit_result_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Decode the incoming index and the in-flight unit's status.
  always_comb begin
    legal    = (int'(unit_idx_i) < NUM_UNITS) && PRESENT_MASK[unit_idx_i];
    is_comb  = legal && COMB_MASK[unit_idx_i];
    sel_res  = legal ? res_arr[unit_idx_i] : '0;
    done_hit = unit_done_i[idx_q];
    timeout  = (cnt_q == TW'(TIMEOUT_CYCLES - 1));
  end

  // Next-state and output decode. The done check precedes the timeout check,
  // so a done in the final cycle is honoured without an error.
  always_comb begin
    state_d      = state_q;
    ready_o      = 1'b1;
    result_o     = '0;
    unit_start_o = '0;
    unit_op_a_o  = op_a_q;
    unit_op_b_o  = op_b_q;
    unit_op_c_o  = op_c_q;
    launch       = 1'b0;
    err_set      = 1'b0;
    case (state_q)
      S_IDLE: begin
        unit_op_a_o = op_a_i;
        unit_op_b_o = op_b_i;
        unit_op_c_o = op_c_i;
        if (enable_i) begin
          if (!legal) begin
            err_set = 1'b1;
          end else if (is_comb) begin
            result_o = sel_res;
          end else begin
            launch                   = 1'b1;
            unit_start_o[unit_idx_i] = 1'b1;
            ready_o                  = 1'b0;
            state_d                  = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        ready_o = 1'b0;
        if (done_hit) begin
          state_d = S_HOLD;
        end else if (timeout) begin
          err_set = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        result_o = result_q;
        if (ex_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign multicycle_o = ~ready_o;
  assign error_o      = error_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Latch operands at launch, count BUSY cycles, and capture the result or a zero on timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_c_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else if (launch) begin
      idx_q  <= unit_idx_i;
      op_a_q <= op_a_i;
      op_b_q <= op_b_i;
      op_c_q <= op_c_i;
      cnt_q  <= '0;
    end else if (state_q == S_BUSY) begin
      cnt_q <= cnt_q + TW'(1);
      if (done_hit)     result_q <= res_arr[idx_q];
      else if (timeout) result_q <= '0;
    end
  end

  // Sticky error flag. When a set and a clear coincide, the set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         error_q <= 1'b0;
    else if (err_set)   error_q <= 1'b1;
    else if (err_clr_i) error_q <= 1'b0;
  end

endmodule

// File: tb/tb_pq_accel_dispatch.sv
// Bench for pq_accel_dispatch.
// Two instances share one stimulus: "m" uses the default timeout, and "t" uses a 4-cycle timeout.
module tb_pq_accel_dispatch;
  localparam int N  = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable, ex_ready, err_clr;
  logic [2:0]    idx;
  logic [DW-1:0] op_a, op_b, op_c;
  logic [N-1:0]  done;
  logic [N*DW-1:0] unit_res;

  logic [DW-1:0] m_result, m_op_a, m_op_b, m_op_c, t_result, t_op_a, t_op_b, t_op_c;
  logic          m_ready, m_multi, m_error, t_ready, t_multi, t_error;
  logic [N-1:0]  m_start, t_start;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb_q [$];

  always #5 clk = ~clk;

  pq_accel_dispatch #(.PRESENT_MASK(8'h7F)) dut_m (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .unit_idx_i(idx),
    .op_a_i(op_a), .op_b_i(op_b), .op_c_i(op_c), .ex_ready_i(ex_ready), .err_clr_i(err_clr),
    .result_o(m_result), .ready_o(m_ready), .multicycle_o(m_multi), .error_o(m_error),
    .unit_start_o(m_start), .unit_op_a_o(m_op_a), .unit_op_b_o(m_op_b), .unit_op_c_o(m_op_c),
    .unit_done_i(done), .unit_result_i(unit_res));

  pq_accel_dispatch #(.PRESENT_MASK(8'h7F), .TIMEOUT_CYCLES(4), .TW(3)) dut_t (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .unit_idx_i(idx),
    .op_a_i(op_a), .op_b_i(op_b), .op_c_i(op_c), .ex_ready_i(ex_ready), .err_clr_i(err_clr),
    .result_o(t_result), .ready_o(t_ready), .multicycle_o(t_multi), .error_o(t_error),
    .unit_start_o(t_start), .unit_op_a_o(t_op_a), .unit_op_b_o(t_op_b), .unit_op_c_o(t_op_c),
    .unit_done_i(done), .unit_result_i(unit_res));

  typedef struct {
    logic          en;
    logic [2:0]    idx;
    logic [DW-1:0] op_a;
    logic [DW-1:0] unit_val;
    logic          exp_ready;
    logic [DW-1:0] exp_result;
    logic [N-1:0]  exp_start;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name, input logic [DW-1:0] act);
    logic [DW-1:0] exp;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty, actual=0x%0h", name, act);
    end else begin
      exp = sb_q.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
    end
  endtask

  task automatic set_res(input int u, input logic [DW-1:0] v);
    unit_res[u*DW +: DW] = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Advance cycles until the chosen instance reports ready, up to a fixed budget.
  task automatic wait_ready(input bit use_t, input string name, output int n);
    n = 0;
    while (((use_t ? t_ready : m_ready) !== 1'b1) && n < 64) begin
      step();
      smp();
      n++;
    end
    chk({name, "_ready"}, use_t ? t_ready : m_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall;
    int n;

    vecs[0] = '{1'b0, 3'd1, 32'h0000_0011, 32'h0000_00AB, 1'b1, 32'h0000_0000, 8'h00};
    vecs[1] = '{1'b1, 3'd1, 32'h0000_0022, 32'h0000_00AB, 1'b1, 32'h0000_00AB, 8'h00};
    vecs[2] = '{1'b1, 3'd2, 32'h0000_0033, 32'h5555_0001, 1'b1, 32'h5555_0001, 8'h00};
    vecs[3] = '{1'b1, 3'd7, 32'h0000_0044, 32'h0000_0077, 1'b1, 32'h0000_0000, 8'h00};
    vecs[4] = '{1'b0, 3'd2, 32'h0000_0055, 32'h5555_0001, 1'b1, 32'h0000_0000, 8'h00};

    rst_n = 1'b0; enable = 1'b0; idx = '0; op_a = '0; op_b = '0; op_c = '0;
    ex_ready = 1'b0; err_clr = 1'b0; done = '0; unit_res = '0;

    smp();
    chk("rst_ready", m_ready, 1);
    chk("rst_multi", m_multi, 0);
    chk("rst_start", m_start, 0);
    chk("rst_result", m_result, 0);
    chk("rst_error", m_error, 0);
    step();
    rst_n = 1'b1;

    // Zero-latency cases in IDLE: disabled, comb units, illegal unit.
    for (int i = 0; i < 5; i++) begin
      enable = vecs[i].en;
      idx    = vecs[i].idx;
      op_a   = vecs[i].op_a;
      set_res(int'(vecs[i].idx), vecs[i].unit_val);
      sb_q.push_back(vecs[i].exp_result);
      smp();
      chk($sformatf("vec%0d_ready", i), m_ready, vecs[i].exp_ready);
      sb_check($sformatf("vec%0d_result", i), m_result);
      chk($sformatf("vec%0d_start", i), m_start, vecs[i].exp_start);
      chk($sformatf("vec%0d_op_a", i), m_op_a, vecs[i].op_a);
      step();
    end
    smp();
    chk("illegal_err_m", m_error, 1);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    smp();
    chk("clr_err_m", m_error, 0);
    step();

    // Multicycle unit 0, done arrives 5 cycles after the start.
    enable = 1'b1; idx = 3'd0; op_a = 32'h0000_1234; op_b = 32'hB; op_c = 32'hC;
    set_res(0, 32'hDEAD_BEEF);
    sb_q.push_back(32'hDEAD_BEEF);
    smp();
    chk("mc_start", m_start, 8'h01);
    chk("mc_ready0", m_ready, 0);
    chk("mc_result0", m_result, 0);
    chk("mc_multi", m_multi, 1);
    stall = (m_ready === 1'b0) ? 1 : 0;
    for (int c = 1; c <= 5; c++) begin
      step();
      op_a = 32'hFFFF_0000 + c;
      done = (c == 5) ? 8'h01 : 8'h00;
      smp();
      if (m_ready === 1'b0) stall++;
      chk($sformatf("mc_busy_start%0d", c), m_start, 0);
      chk($sformatf("mc_busy_op_a%0d", c), m_op_a, 32'h0000_1234);
    end
    step();
    done = '0;
    smp();
    chk("mc_stall_cycles", stall, 6);
    chk("mc_ready", m_ready, 1);
    sb_check("mc_result", m_result);

    // Backpressure in HOLD with enable still high.
    for (int h = 0; h < 3; h++) begin
      step();
      smp();
      chk($sformatf("hold_result%0d", h), m_result, 32'hDEAD_BEEF);
      chk($sformatf("hold_ready%0d", h), m_ready, 1);
      chk($sformatf("hold_start%0d", h), m_start, 0);
    end
    step();
    ex_ready = 1'b1;
    smp();
    chk("hold_accept_result", m_result, 32'hDEAD_BEEF);
    step();
    ex_ready = 1'b0;
    enable = 1'b0;
    smp();
    chk("hold_exit_result", m_result, 0);
    chk("hold_exit_ready", m_ready, 1);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    smp();
    chk("t_err_cleared", t_error, 0);
    step();

    // Spurious done from unit 5, then done on the final timeout cycle.
    enable = 1'b1; idx = 3'd3;
    set_res(3, 32'hC0DE_0003);
    set_res(5, 32'h5555_5555);
    smp();
    chk("sp_start", t_start, 8'h08);
    step();
    enable = 1'b0;
    done = 8'h20;
    smp();
    chk("sp_ignore_c1", t_ready, 0);
    step();
    done = '0;
    smp();
    chk("sp_ignore_c2", t_ready, 0);
    step();
    smp();
    step();
    done = 8'h08;
    sb_q.push_back(32'hC0DE_0003);
    smp();
    chk("sp_last_busy", t_ready, 0);
    step();
    done = '0;
    smp();
    chk("sp_ready", t_ready, 1);
    sb_check("sp_result", t_result);
    chk("sp_no_error", t_error, 0);
    step();
    ex_ready = 1'b1;
    step();
    ex_ready = 1'b0;

    // Timeout with no done.
    enable = 1'b1; idx = 3'd0;
    set_res(0, 32'h1111_2222);
    sb_q.push_back(32'h0);
    smp();
    chk("to_start", t_start, 8'h01);
    step();
    enable = 1'b0;
    smp();
    wait_ready(1'b1, "to", n);
    chk("to_busy_cycles", n, 4);
    sb_check("to_result", t_result);
    chk("to_error", t_error, 1);
    step();
    ex_ready = 1'b1;
    err_clr = 1'b1;
    step();
    ex_ready = 1'b0;
    err_clr = 1'b0;
    smp();
    chk("to_err_clr", t_error, 0);
    step();

    // Absent unit 7.
    enable = 1'b1; idx = 3'd7;
    set_res(7, 32'h7777_7777);
    sb_q.push_back(32'h0);
    smp();
    chk("il_ready", t_ready, 1);
    sb_check("il_result", t_result);
    chk("il_start", t_start, 0);
    step();
    enable = 1'b0;
    smp();
    chk("il_error", t_error, 1);
    step();
    enable = 1'b1;
    err_clr = 1'b1;
    step();
    enable = 1'b0;
    err_clr = 1'b0;
    smp();
    chk("il_set_wins", t_error, 1);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    smp();
    chk("il_clr", t_error, 0);
    step();
    enable = 1'b1;
    step();
    enable = 1'b0;

    // Async reset in the middle of BUSY.
    enable = 1'b1; idx = 3'd0;
    smp();
    chk("rs_start", t_start, 8'h01);
    step();
    enable = 1'b0;
    step();
    chk("rs_pre_ready", t_ready, 0);
    chk("rs_pre_error", t_error, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_ready", t_ready, 1);
    chk("rs_multi", t_multi, 0);
    chk("rs_error", t_error, 0);
    chk("rs_start_t", t_start, 0);
    chk("rs_ready_m", m_ready, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    smp();
    chk("rs_post_start", t_start, 0);
    chk("rs_post_ready", t_ready, 1);
    step();
    smp();
    chk("rs_post_start2", t_start, 0);

    // Fresh dispatch after reset: unit 4, done one cycle after the start.
    step();
    enable = 1'b1; idx = 3'd4; op_a = 32'h4;
    set_res(4, 32'h4444_0004);
    sb_q.push_back(32'h4444_0004);
    smp();
    chk("nd_start", m_start, 8'h10);
    step();
    enable = 1'b0;
    done = 8'h10;
    smp();
    chk("nd_busy", m_ready, 0);
    step();
    done = '0;
    smp();
    wait_ready(1'b0, "nd", n);
    chk("nd_latency", n, 0);
    sb_check("nd_result", m_result);
    chk("nd_error", m_error, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
